// File: rtl/reg_wb_arbiter.sv
// reg_wb_arbiter
//   Shares the single register-file write port between two writers:
//   port 0 = pipeline writeback stage, port 1 = side writer (trap unit,
//   late load return). Fixed priority to port 0, with a starvation guard
//   that forces port 1 first after it has waited STARVE_LIMIT cycles.
// Ports
//   clk_50MHz   system clock, all state on rising edge
//   rst         synchronous reset, active-high
//   hold        1 = grant nothing this cycle (freeze / flush)
//   pN_valid    port N write request
//   pN_ready    port N accepted this cycle (combinational)
//   pN_op/addr/data  port N write selector / general-reg index / data
//   reg_op, wb_addr, wb_data  registered write to register file
//   starved     registered; 1 while port 1 holds forced priority
module reg_wb_arbiter #(
    parameter int DATA_W                = 16,
    parameter int ADDR_W                = 3,
    parameter int OP_W                  = 3,
    parameter logic [OP_W-1:0] OP_NOP   = 3'd0,
    parameter int STARVE_LIMIT          = 4
) (
    input  logic              clk_50MHz,
    input  logic              rst,
    input  logic              hold,
    input  logic              p0_valid,
    output logic              p0_ready,
    input  logic [OP_W-1:0]   p0_op,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_data,
    input  logic              p1_valid,
    output logic              p1_ready,
    input  logic [OP_W-1:0]   p1_op,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_data,
    output logic [OP_W-1:0]   reg_op,
    output logic [ADDR_W-1:0] wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic              starved
);
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    typedef enum logic {PRI0, PRI1} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] wait_cnt, cnt_nxt, cnt_inc;
    logic             grant_en, grant0, grant1;
    logic [OP_W-1:0]  win_op;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_data;

    // Grants are masked by rst so a request presented during reset is
    // never consumed by the requester.
    assign grant_en = ~rst & ~hold;
    assign grant1   = grant_en & p1_valid & ((state == PRI1) | ~p0_valid);
    assign grant0   = grant_en & p0_valid & ~((state == PRI1) & p1_valid);
    assign p0_ready = grant0;
    assign p1_ready = grant1;

    assign win_op   = grant1 ? p1_op   : p0_op;
    assign win_addr = grant1 ? p1_addr : p0_addr;
    assign win_data = grant1 ? p1_data : p0_data;

    // Saturating increment; the counter never needs to exceed LIMIT.
    assign cnt_inc = (wait_cnt == LIMIT) ? wait_cnt : wait_cnt + CNT_W'(1);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = wait_cnt;
        if (!hold) begin
            case (state)
                PRI0: begin
                    if (p1_valid && !grant1) begin
                        cnt_nxt = cnt_inc;
                        if (cnt_inc == LIMIT) state_nxt = PRI1;
                    end else begin
                        cnt_nxt = '0;
                    end
                end
                PRI1: begin
                    // Leave forced priority once port 1 is served or withdraws.
                    if (grant1 || !p1_valid) begin
                        state_nxt = PRI0;
                        cnt_nxt   = '0;
                    end
                end
                default: begin
                    state_nxt = PRI0;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_50MHz) begin
        if (rst) begin
            state    <= PRI0;
            wait_cnt <= '0;
            starved  <= 1'b0;
            reg_op   <= OP_NOP;
            wb_addr  <= '0;
            wb_data  <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= cnt_nxt;
            starved  <= (state_nxt == PRI1);
            // A granted NOP is consumed but leaves addr/data untouched, same
            // as an idle cycle; only real writes update the address/data.
            if ((grant0 || grant1) && (win_op != OP_NOP)) begin
                reg_op  <= win_op;
                wb_addr <= win_addr;
                wb_data <= win_data;
            end else begin
                reg_op  <= OP_NOP;
            end
        end
    end
endmodule
